// File: rtl/wfall_pkg.sv
// Shared definitions for the waterfall framebuffer controller: FSM state
// encoding, default display geometry and width helper functions.
package wfall_pkg;

  // Controller states; the top module mirrors these as logic [1:0] constants
  typedef enum logic [1:0] {
    WF_INIT    = 2'd0,
    WF_IDLE    = 2'd1,
    WF_CAPTURE = 2'd2
  } wfall_state_e;

  // Default geometry of the 320x240 LCD panel and the 12-bit ADC
  localparam int DEF_WIDTH    = 320;
  localparam int DEF_HEIGHT   = 240;
  localparam int DEF_PIX_W    = 8;
  localparam int DEF_SAMPLE_W = 12;
  localparam int DEF_DECIM    = 1;
  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;

  // Counter width able to hold 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address width needed to cover a w x h framebuffer
  function automatic int fb_addr_w(input int w, input int h);
    return cnt_w(w * h);
  endfunction

  localparam int DEF_ADDR_W = fb_addr_w(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/wfall_decimator.sv
// Sample decimator for the waterfall controller: accepts ADC samples while
// enabled, counts DECIM samples per pixel and emits one pixel per group.
// Build option: WFALL_PEAK_HOLD_EN selects the maximum of each group;
// without it the first sample of each group is kept and the rest dropped.
module wfall_decimator
  import wfall_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int DECIM    = DEF_DECIM
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic                pix_valid,
  output logic [PIX_W-1:0]    pix_data
);

  localparam int DCNT_W = cnt_w(DECIM);

  logic [DCNT_W-1:0]   dcnt_reg;
  logic [SAMPLE_W-1:0] acc_reg;
  logic [SAMPLE_W-1:0] acc_next;
  logic                accept;
  logic                group_last;

  assign sample_ready = enable;
  assign accept       = sample_valid && enable;
  assign group_last   = (dcnt_reg == DCNT_W'(DECIM - 1));

  // Accumulator update: the first sample of a group always restarts it
  always_comb begin
    acc_next = acc_reg;
    if (dcnt_reg == '0) begin
      acc_next = sample_data;
`ifdef WFALL_PEAK_HOLD_EN
    end else if (sample_data > acc_reg) begin
      acc_next = sample_data;
`endif
    end
  end

  // The last sample of a group completes the pixel in the same cycle
  assign pix_valid = accept && group_last;
  assign pix_data  = acc_next[SAMPLE_W-1 -: PIX_W];

  // Group counter and accumulator; clear drops any partial group at row start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt_reg <= '0;
      acc_reg  <= '0;
    end else if (clear) begin
      dcnt_reg <= '0;
    end else if (accept) begin
      acc_reg  <= acc_next;
      dcnt_reg <= group_last ? '0 : dcnt_reg + DCNT_W'(1);
    end
  end

endmodule

// File: rtl/waterfall_fb_ctrl.sv
// Waterfall framebuffer controller: clears the RAM after reset, captures one
// decimated sample row into the oldest RAM row each vertical blank and
// rotates the row pointer so the newest row is shown at y=0. During active
// video it issues row-rotated pixel read addresses.
// Build option: WFALL_PEAK_HOLD_EN (peak hold decimation, see wfall_decimator).
module waterfall_fb_ctrl
  import wfall_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DECIM    = DEF_DECIM,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                visible,
  input  logic                lower_blank,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [PIX_W-1:0]    ram_wdata,
  output logic                ram_we,
  output logic                init_done,
  output logic                row_strobe
);

  localparam int ROW_W  = cnt_w(HEIGHT);
  localparam int COL_W  = cnt_w(WIDTH);
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int INIT_W = ADDR_W + 1;

  localparam logic [1:0] INIT    = WF_INIT;
  localparam logic [1:0] IDLE    = WF_IDLE;
  localparam logic [1:0] CAPTURE = WF_CAPTURE;

  logic [1:0]        state_reg;
  logic              blank_prev_reg;
  logic [ROW_W-1:0]  top_row_reg;
  logic [ROW_W-1:0]  wr_row_reg;
  logic [COL_W-1:0]  col_reg;
  logic [INIT_W-1:0] init_cnt_reg;

  logic              blank_rise;
  logic              dec_enable;
  logic              dec_clear;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic [ADDR_W-1:0] rd_sum;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              col_last;

  assign blank_rise = lower_blank && !blank_prev_reg;
  // Sampling pauses during active video so writes never collide with reads
  assign dec_enable = (state_reg == CAPTURE) && !visible;
  assign dec_clear  = (state_reg == IDLE) && blank_rise;
  assign col_last   = (col_reg == COL_W'(WIDTH - 1));

  wfall_decimator #(
    .SAMPLE_W (SAMPLE_W),
    .PIX_W    (PIX_W),
    .DECIM    (DECIM)
  ) u_decim (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (dec_enable),
    .clear        (dec_clear),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data)
  );

  // Address arithmetic: rotated display row and the capture write address
  always_comb begin
    rd_sum  = ADDR_W'(y) + ADDR_W'(top_row_reg);
    rd_row  = (rd_sum >= ADDR_W'(HEIGHT)) ? rd_sum - ADDR_W'(HEIGHT) : rd_sum;
    rd_addr = rd_row * ADDR_W'(WIDTH) + ADDR_W'(x);
    wr_addr = ADDR_W'(wr_row_reg) * ADDR_W'(WIDTH) + ADDR_W'(col_reg);
  end

  // Controller FSM: clear pass, wait for blank, capture one row, commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= INIT;
      blank_prev_reg <= 1'b0;
      top_row_reg    <= '0;
      wr_row_reg     <= '0;
      col_reg        <= '0;
      init_cnt_reg   <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      init_done      <= 1'b0;
      row_strobe     <= 1'b0;
    end else begin
      blank_prev_reg <= lower_blank;
      row_strobe     <= 1'b0;
      case (state_reg)
        INIT: begin
          if (init_cnt_reg == INIT_W'(TOTAL)) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            init_done <= 1'b1;
            state_reg <= IDLE;
          end else begin
            ram_we       <= 1'b1;
            ram_addr     <= init_cnt_reg[ADDR_W-1:0];
            ram_wdata    <= '0;
            init_cnt_reg <= init_cnt_reg + INIT_W'(1);
          end
        end
        CAPTURE: begin
          if (pix_valid) begin
            ram_we    <= 1'b1;
            ram_addr  <= wr_addr;
            ram_wdata <= pix_data;
            if (col_last) begin
              top_row_reg <= wr_row_reg;
              row_strobe  <= 1'b1;
              col_reg     <= '0;
              state_reg   <= IDLE;
            end else begin
              col_reg <= col_reg + COL_W'(1);
            end
          end else begin
            ram_we   <= 1'b0;
            ram_addr <= visible ? rd_addr : '0;
          end
        end
        default: begin
          // IDLE, and recovery path for the unused encoding
          ram_we   <= 1'b0;
          ram_addr <= visible ? rd_addr : '0;
          if (state_reg != IDLE) begin
            state_reg <= IDLE;
          end else if (blank_rise) begin
            wr_row_reg <= (top_row_reg == '0) ? ROW_W'(HEIGHT - 1)
                                              : top_row_reg - ROW_W'(1);
            col_reg    <= '0;
            state_reg  <= CAPTURE;
          end
        end
      endcase
    end
  end

endmodule
